// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and types shared by the fetch and decode stages.
package fetch_pkg;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_REG = 7'b0110011;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } entry_t;
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of fetched words; entries fill in request order.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          push,
   input  logic [31:0]   push_pc,
   input  logic          fill,
   input  logic [31:0]   fill_data,
   input  logic          pop,
   output logic [31:0]   head_pc,
   output logic [31:0]   head_data,
   output logic          head_filled,
   output logic [CW-1:0] count,
   output logic [CW-1:0] unfilled
);
   localparam int PW = $clog2(DEPTH);
   entry_t mem_q [DEPTH];
   entry_t mem_d [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d, fptr_q, fptr_d;
   logic [CW-1:0] count_q, count_d, unf_q, unf_d;
   logic do_fill, do_pop;

   // filled entries are always a contiguous run starting at the head
   assign head_filled = count_q > unf_q;
   assign head_pc = mem_q[head_q].pc;
   assign head_data = mem_q[head_q].data;
   assign count = count_q;
   assign unfilled = unf_q;

   always_comb begin
      mem_d = mem_q;
      do_fill = fill && unf_q != '0;
      do_pop = pop && head_filled;
      head_d = head_q + PW'(do_pop);
      tail_d = tail_q + PW'(push);
      fptr_d = fptr_q + PW'(do_fill);
      count_d = count_q + CW'(push) - CW'(do_pop);
      unf_d = unf_q + CW'(push) - CW'(do_fill);
      if (push) mem_d[tail_q] = '{pc: push_pc, data: NOP_INST};
      if (do_fill) mem_d[fptr_q].data = fill_data;
      if (clear) begin
         head_d = '0;
         tail_d = '0;
         fptr_d = '0;
         count_d = '0;
         unf_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         fptr_q <= '0;
         count_q <= '0;
         unf_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         fptr_q <= fptr_d;
         count_q <= count_d;
         unf_q <= unf_d;
      end
   end

   always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/fetch.sv
// fetch: program counter, in-order instruction reads and head-of-queue presentation to decode.
module fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] START_ADDR = 32'h0000_0000,
   parameter int DEPTH = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        FLUSH,
   input  logic [31:0] FLUSH_PC,
   input  logic        STALL,
   output logic        MEM_WAIT,
   output logic [31:0] INST_PC,
   output logic [31:0] INST_DATA,
   output logic        INST_RDEN,
   output logic [31:0] INST_RDADDR,
   input  logic        INST_RDREADY,
   input  logic        INST_RDVALID,
   input  logic [31:0] INST_RDDATA
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int SW = CW + 1;
   logic [31:0] pc_q, pc_d, head_pc, head_data;
   logic [CW-1:0] discard_q, discard_d, count, unfilled;
   logic [SW-1:0] inflight, stale;
   logic head_filled, pop, accept, fill;

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk(CLK),
      .rst_n(RST),
      .clear(FLUSH),
      .push(accept),
      .push_pc(pc_q),
      .fill(fill),
      .fill_data(INST_RDDATA),
      .pop(pop),
      .head_pc(head_pc),
      .head_data(head_data),
      .head_filled(head_filled),
      .count(count),
      .unfilled(unfilled)
   );

   assign MEM_WAIT = !head_filled;
   assign INST_PC = head_filled ? head_pc : '0;
   assign INST_DATA = head_filled ? head_data : NOP_INST;
   assign INST_RDADDR = pc_q;

   always_comb begin
      pop = head_filled && !STALL && !FLUSH;
      inflight = {1'b0, count} - SW'(pop) + {1'b0, discard_q};
      INST_RDEN = RST && !FLUSH && inflight < SW'(DEPTH);
      accept = INST_RDEN && INST_RDREADY;
      fill = INST_RDVALID && discard_q == '0 && !FLUSH;
      // on redirect every unfilled entry becomes a stale response to swallow
      stale = {1'b0, discard_q} + {1'b0, unfilled};
      pc_d = accept ? pc_q + 32'd4 : pc_q;
      discard_d = discard_q - CW'(INST_RDVALID && discard_q != '0);
      if (FLUSH) begin
         pc_d = word_align(FLUSH_PC);
         discard_d = CW'(stale - SW'(INST_RDVALID && stale != '0));
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         pc_q <= START_ADDR;
         discard_q <= '0;
      end else begin
         pc_q <= pc_d;
         discard_q <= discard_d;
      end
   end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed checks of fetch against an in-order memory model with configurable latency.
module tb_fetch;
   import fetch_pkg::*;
   logic CLK = 0, RST = 0, FLUSH = 0, STALL = 0, INST_RDREADY = 1, INST_RDVALID = 0;
   logic [31:0] FLUSH_PC = '0, INST_RDDATA = '0;
   logic MEM_WAIT, INST_RDEN;
   logic [31:0] INST_PC, INST_DATA, INST_RDADDR;
   int checks = 0, errors = 0, lat = 1, cyc = 0;
   typedef struct {
      logic [31:0] addr;
      int due;
   } req_t;
   req_t mq[$];
   logic [31:0] wrap_a [3] = '{32'hffff_fff8, 32'hffff_fffc, 32'h0000_0000};

   always #5 CLK = ~CLK;

   fetch #(.START_ADDR(32'h100), .DEPTH(4)) dut (
      .CLK(CLK),
      .RST(RST),
      .FLUSH(FLUSH),
      .FLUSH_PC(FLUSH_PC),
      .STALL(STALL),
      .MEM_WAIT(MEM_WAIT),
      .INST_PC(INST_PC),
      .INST_DATA(INST_DATA),
      .INST_RDEN(INST_RDEN),
      .INST_RDADDR(INST_RDADDR),
      .INST_RDREADY(INST_RDREADY),
      .INST_RDVALID(INST_RDVALID),
      .INST_RDDATA(INST_RDDATA)
   );

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return a ^ 32'h5a5a_a5a5;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic next(input logic st, input logic fl, input logic [31:0] fpc);
      @(posedge CLK);
      #1;
      STALL = st;
      FLUSH = fl;
      FLUSH_PC = fpc;
      #1;
   endtask

   // memory: a request accepted in cycle t answers in cycle t+lat, strictly in order
   initial begin : mem_model
      logic acc, was_valid;
      logic [31:0] a;
      forever begin
         @(posedge CLK or negedge RST);
         if (!RST) begin
            mq.delete();
            cyc = 0;
            INST_RDVALID = 0;
         end else begin
            acc = INST_RDEN && INST_RDREADY;
            a = INST_RDADDR;
            was_valid = INST_RDVALID;
            #1;
            if (was_valid && mq.size() > 0) void'(mq.pop_front());
            if (acc) mq.push_back('{a, cyc + lat});
            cyc++;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
               INST_RDVALID = 1;
               INST_RDDATA = mdata(mq[0].addr);
            end else INST_RDVALID = 0;
         end
      end
   end

   initial begin
      next(0, 0, 0);
      chk("rst_wait", MEM_WAIT, 1);
      chk("rst_pc", INST_PC, 0);
      chk("rst_data", INST_DATA, NOP_INST);
      chk("rst_rden", INST_RDEN, 0);
      next(0, 0, 0);
      RST = 1;
      #1;
      chk("first_rden", INST_RDEN, 1);
      chk("first_addr", INST_RDADDR, 32'h100);
      next(0, 0, 0);
      chk("warm_wait", MEM_WAIT, 1);
      chk("warm_addr", INST_RDADDR, 32'h104);
      for (int k = 0; k < 8; k++) begin
         next(0, 0, 0);
         chk("stream_wait", MEM_WAIT, 0);
         chk("stream_pc", INST_PC, 32'h100 + 4 * k);
         chk("stream_data", INST_DATA, mdata(32'h100 + 4 * k));
         chk("stream_addr", INST_RDADDR, 32'h108 + 4 * k);
      end
      for (int s = 0; s < 6; s++) begin
         next(1, 0, 0);
         chk("stall_pc", INST_PC, 32'h120);
         chk("stall_data", INST_DATA, mdata(32'h120));
         chk("stall_rden", INST_RDEN, s < 2 ? 1 : 0);
      end
      for (int i = 0; i < 6; i++) begin
         next(0, 0, 0);
         chk("release_wait", MEM_WAIT, 0);
         chk("release_pc", INST_PC, 32'h120 + 4 * i);
      end
      for (int s = 0; s < 4; s++) next(1, 0, 0);
      chk("full_rden", INST_RDEN, 0);
      #3;
      RST = 0;
      #1;
      chk("async_rst_wait", MEM_WAIT, 1);
      chk("async_rst_pc", INST_PC, 0);
      chk("async_rst_data", INST_DATA, NOP_INST);
      chk("async_rst_rden", INST_RDEN, 0);
      lat = 3;
      next(0, 0, 0);
      next(0, 0, 0);
      RST = 1;
      #1;
      chk("rerst_rden", INST_RDEN, 1);
      chk("rerst_addr", INST_RDADDR, 32'h100);
      next(0, 0, 0);
      next(0, 0, 0);
      next(0, 1, 32'h2002);
      chk("flush_rden", INST_RDEN, 0);
      next(0, 0, 0);
      chk("redir_rden", INST_RDEN, 1);
      chk("redir_addr", INST_RDADDR, 32'h2000);
      chk("redir_wait", MEM_WAIT, 1);
      chk("redir_pc", INST_PC, 0);
      chk("redir_data", INST_DATA, NOP_INST);
      next(0, 0, 0);
      next(0, 0, 0);
      next(0, 0, 0);
      chk("slow_wait", MEM_WAIT, 1);
      next(1, 1, 32'h3000);
      chk("redir_head_wait", MEM_WAIT, 0);
      chk("redir_head_pc", INST_PC, 32'h2000);
      chk("redir_head_data", INST_DATA, mdata(32'h2000));
      chk("flush2_rden", INST_RDEN, 0);
      next(0, 0, 0);
      chk("flush2_wait", MEM_WAIT, 1);
      chk("flush2_data", INST_DATA, NOP_INST);
      chk("flush2_rden_after", INST_RDEN, 1);
      chk("flush2_addr", INST_RDADDR, 32'h3000);
      next(0, 0, 0);
      chk("flush2_rden_next", INST_RDEN, 1);
      chk("flush2_addr_next", INST_RDADDR, 32'h3004);
      next(0, 0, 0);
      next(0, 0, 0);
      next(0, 1, 32'hffff_fff9);
      chk("flush2_head_wait", MEM_WAIT, 0);
      chk("flush2_head_pc", INST_PC, 32'h3000);
      chk("flush2_head_data", INST_DATA, mdata(32'h3000));
      for (int i = 0; i < 3; i++) begin
         next(0, 0, 0);
         chk("wrap_rden", INST_RDEN, 1);
         chk("wrap_addr", INST_RDADDR, wrap_a[i]);
      end
      next(0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         next(0, 0, 0);
         chk("wrap_wait", MEM_WAIT, 0);
         chk("wrap_pc", INST_PC, wrap_a[i]);
         chk("wrap_data", INST_DATA, mdata(wrap_a[i]));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
